// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, port owner,
// and the memory access size codes (also used by setMemSize).
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  typedef enum logic {
    OWN_DATA  = 1'b0,
    OWN_FETCH = 1'b1
  } owner_e;

  localparam logic [1:0] MEM_BYTE = 2'b00;
  localparam logic [1:0] MEM_HALF = 2'b01;
  localparam logic [1:0] MEM_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_dffrec.sv
// dffREC: W-bit register, async active-high reset to 0, load enable.
// Ports: clk_i, rst_i, en_i, d_i[W] -> q_o[W].
module dffREC #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     q_o <= '0;
    else if (en_i) q_o <= d_i;
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single memory port shared by IF and MEM; data has priority, one
// transaction in flight. Ports: fetch req/resp, data req/resp, stalls, mem.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_fetchReq,
  input  logic [ADDR_W-1:0] i_fetchAddr,
  input  logic              i_fetchKill,
  output logic [DATA_W-1:0] o_fetchData,
  output logic              o_fetchValid,
  input  logic              i_dataReq,
  input  logic              i_dataWrite,
  input  logic [1:0]        i_dataSize,
  input  logic [ADDR_W-1:0] i_dataAddr,
  input  logic [DATA_W-1:0] i_dataWData,
  output logic [DATA_W-1:0] o_dataRData,
  output logic              o_dataValid,
  output logic              o_stallF,
  output logic              o_stallM,
  output logic              o_memReq,
  output logic              o_memWrite,
  output logic [1:0]        o_memSize,
  output logic [ADDR_W-1:0] o_memAddr,
  output logic [DATA_W-1:0] o_memWData,
  input  logic              i_memReady,
  input  logic              i_memRValid,
  input  logic [DATA_W-1:0] i_memRData
);

  localparam int REQ_W = 1 + 2 + ADDR_W + DATA_W;

  state_e            state_q;
  owner_e            owner_q;
  logic              kill_q;
  logic              memReq_q;
  logic              dValid_q;
  logic              fValid_q;
  logic [DATA_W-1:0] rdata_q;

  logic              grantD;
  logic              grantF;
  logic [REQ_W-1:0]  req_d;
  logic [REQ_W-1:0]  req_q;
  logic              killHit;

  // A killed fetch in IDLE is simply never granted.
  assign grantD = (state_q == ST_IDLE) & i_dataReq;
  assign grantF = (state_q == ST_IDLE) & ~i_dataReq
                & i_fetchReq & ~i_fetchKill;

  always_comb begin
    req_d = {1'b0, MEM_WORD, i_fetchAddr, {DATA_W{1'b0}}};
    if (grantD)
      req_d = {i_dataWrite, i_dataSize, i_dataAddr, i_dataWData};
  end

  dffREC #(.W(REQ_W)) u_req (
    .clk_i (clk),
    .rst_i (reset),
    .en_i  (grantD | grantF),
    .d_i   (req_d),
    .q_o   (req_q)
  );

  assign {o_memWrite, o_memSize, o_memAddr, o_memWData} = req_q;

  // Kill seen in the same cycle as rvalid must still suppress the pulse.
  assign killHit = (owner_q == OWN_FETCH) & i_fetchKill;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      owner_q  <= OWN_DATA;
      kill_q   <= 1'b0;
      memReq_q <= 1'b0;
      dValid_q <= 1'b0;
      fValid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      dValid_q <= 1'b0;
      fValid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (grantD) begin
            owner_q  <= OWN_DATA;
            memReq_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end else if (grantF) begin
            owner_q  <= OWN_FETCH;
            memReq_q <= 1'b1;
            state_q  <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (killHit) kill_q <= 1'b1;
          if (i_memReady) begin
            memReq_q <= 1'b0;
            state_q  <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (killHit) kill_q <= 1'b1;
          if (i_memRValid) begin
            rdata_q  <= i_memRData;
            dValid_q <= (owner_q == OWN_DATA);
            fValid_q <= (owner_q == OWN_FETCH)
                      & ~(kill_q | i_fetchKill);
            state_q  <= ST_RESP;
          end
        end
        ST_RESP: begin
          kill_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_memReq     = memReq_q;
  assign o_dataValid  = dValid_q;
  assign o_fetchValid = fValid_q;
  assign o_dataRData  = rdata_q;
  assign o_fetchData  = rdata_q;
  assign o_stallF     = i_fetchReq & ~o_fetchValid;
  assign o_stallM     = i_dataReq & ~o_dataValid;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a small memory model
// and expected-response queues for the fetch and data ports.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_fetchReq;
  logic [31:0] i_fetchAddr;
  logic        i_fetchKill;
  logic [31:0] o_fetchData;
  logic        o_fetchValid;
  logic        i_dataReq;
  logic        i_dataWrite;
  logic [1:0]  i_dataSize;
  logic [31:0] i_dataAddr;
  logic [31:0] i_dataWData;
  logic [31:0] o_dataRData;
  logic        o_dataValid;
  logic        o_stallF;
  logic        o_stallM;
  logic        o_memReq;
  logic        o_memWrite;
  logic [1:0]  o_memSize;
  logic [31:0] o_memAddr;
  logic [31:0] o_memWData;
  logic        i_memReady;
  logic        i_memRValid;
  logic [31:0] i_memRData;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_fetchReq   (i_fetchReq),
    .i_fetchAddr  (i_fetchAddr),
    .i_fetchKill  (i_fetchKill),
    .o_fetchData  (o_fetchData),
    .o_fetchValid (o_fetchValid),
    .i_dataReq    (i_dataReq),
    .i_dataWrite  (i_dataWrite),
    .i_dataSize   (i_dataSize),
    .i_dataAddr   (i_dataAddr),
    .i_dataWData  (i_dataWData),
    .o_dataRData  (o_dataRData),
    .o_dataValid  (o_dataValid),
    .o_stallF     (o_stallF),
    .o_stallM     (o_stallM),
    .o_memReq     (o_memReq),
    .o_memWrite   (o_memWrite),
    .o_memSize    (o_memSize),
    .o_memAddr    (o_memAddr),
    .o_memWData   (o_memWData),
    .i_memReady   (i_memReady),
    .i_memRValid  (i_memRValid),
    .i_memRData   (i_memRData)
  );

  int ntests = 0;
  int nfail  = 0;

  logic [31:0] dq[$];
  logic [31:0] fq[$];

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- memory model ----------------
  int          ready_wait = 0;
  logic        hold_rv    = 1'b0;
  int          issue_cnt  = 0;
  logic        rv_q       = 1'b0;
  logic [31:0] rd_q       = '0;
  logic        pend       = 1'b0;
  logic [31:0] pend_d     = '0;
  logic [31:0] mem  [0:1023];
  logic        wr_v [0:1023];
  logic [9:0]  idx;
  logic [31:0] resp;

  assign idx         = o_memAddr[11:2];
  assign i_memReady  = o_memReq && (issue_cnt >= ready_wait);
  assign i_memRValid = rv_q;
  assign i_memRData  = rd_q;

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEAD_BEEF : (a ^ 32'h5A5A_0000);
  endfunction

  assign resp = o_memWrite ? 32'h0 :
                (wr_v[idx] ? mem[idx] : dflt(o_memAddr));

  always @(posedge clk) begin
    rv_q <= 1'b0;
    if (!o_memReq || i_memReady) issue_cnt <= 0;
    else                         issue_cnt <= issue_cnt + 1;
    if (reset)
      for (int i = 0; i < 1024; i++) wr_v[i] <= 1'b0;
    if (pend && !hold_rv) begin
      rv_q <= 1'b1;
      rd_q <= pend_d;
      pend <= 1'b0;
    end
    if (o_memReq && i_memReady) begin
      if (o_memWrite) begin
        mem[idx]  <= o_memWData;
        wr_v[idx] <= 1'b1;
      end
      if (hold_rv) begin
        pend   <= 1'b1;
        pend_d <= resp;
      end else begin
        rv_q <= 1'b1;
        rd_q <= resp;
      end
    end
  end

  // ---------------- response scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (o_dataValid) begin
        if (dq.size() == 0) chk("d_unexpected", 1, 0);
        else chk("d_rdata", o_dataRData, dq.pop_front());
      end
      if (o_fetchValid) begin
        if (fq.size() == 0) chk("f_unexpected", 1, 0);
        else chk("f_data", o_fetchData, fq.pop_front());
      end
    end
  end

  task automatic wait_valid(input bit isData);
    bit seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      @(negedge clk);
      seen = isData ? o_dataValid : o_fetchValid;
    end
    if (!seen) chk(isData ? "d_timeout" : "f_timeout", 0, 1);
  endtask

  task automatic drv;
    @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    reset       = 1'b1;
    i_fetchReq  = 0;
    i_fetchAddr = '0;
    i_fetchKill = 0;
    i_dataReq   = 0;
    i_dataWrite = 0;
    i_dataSize  = 2'b10;
    i_dataAddr  = '0;
    i_dataWData = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_memReq", o_memReq, 0);
    chk("rst_memAddr", o_memAddr, 0);
    chk("rst_fValid", o_fetchValid, 0);
    chk("rst_dValid", o_dataValid, 0);
    chk("rst_fData", o_fetchData, 0);
    chk("rst_stallF", o_stallF, 0);
    drv();
    reset = 1'b0;

    // load 0x100, zero-wait memory
    drv();
    i_dataReq  = 1;
    i_dataAddr = 32'h100;
    dq.push_back(32'hDEAD_BEEF);
    @(negedge clk);
    chk("t1_stallM_t0", o_stallM, 1);
    chk("t1_memReq_t0", o_memReq, 0);
    @(negedge clk);
    chk("t1_memReq_t1", o_memReq, 1);
    chk("t1_addr", o_memAddr, 32'h100);
    chk("t1_write", o_memWrite, 0);
    chk("t1_stallM_t1", o_stallM, 1);
    @(negedge clk);
    chk("t1_stallM_t2", o_stallM, 1);
    chk("t1_memReq_t2", o_memReq, 0);
    @(negedge clk);
    chk("t1_dValid_t3", o_dataValid, 1);
    chk("t1_stallM_t3", o_stallM, 0);
    drv();
    i_dataReq = 0;
    repeat (2) @(negedge clk);

    // fetch 0x0 and store 0x200 together: store first
    drv();
    i_fetchReq  = 1;
    i_fetchAddr = 32'h0;
    i_dataReq   = 1;
    i_dataWrite = 1;
    i_dataAddr  = 32'h200;
    i_dataWData = 32'h1234_5678;
    dq.push_back(32'h0);
    fq.push_back(32'h5A5A_0000);
    @(negedge clk);
    @(negedge clk);
    chk("t2_memReq", o_memReq, 1);
    chk("t2_write", o_memWrite, 1);
    chk("t2_addr", o_memAddr, 32'h200);
    chk("t2_wdata", o_memWData, 32'h1234_5678);
    chk("t2_stallF_t1", o_stallF, 1);
    @(negedge clk);
    @(negedge clk);
    chk("t2_dValid", o_dataValid, 1);
    chk("t2_fValid", o_fetchValid, 0);
    chk("t2_stallF_t3", o_stallF, 1);
    drv();
    i_dataReq   = 0;
    i_dataWrite = 0;
    @(negedge clk);
    chk("t2_stallF_t4", o_stallF, 1);
    chk("t2_memReq_t4", o_memReq, 0);
    @(negedge clk);
    chk("t2_f_memReq", o_memReq, 1);
    chk("t2_f_addr", o_memAddr, 32'h0);
    chk("t2_f_write", o_memWrite, 0);
    chk("t2_f_wdata", o_memWData, 0);
    chk("t2_f_size", o_memSize, 2'b10);
    wait_valid(0);
    drv();
    i_fetchReq = 0;

    // load back the stored word, byte size passed through
    drv();
    i_dataReq  = 1;
    i_dataAddr = 32'h200;
    i_dataSize = 2'b00;
    dq.push_back(32'h1234_5678);
    @(negedge clk);
    @(negedge clk);
    chk("t2b_size", o_memSize, 2'b00);
    wait_valid(1);
    drv();
    i_dataReq  = 0;
    i_dataSize = 2'b10;

    // fetch with kill in IDLE is ignored
    drv();
    i_fetchReq  = 1;
    i_fetchAddr = 32'h60;
    i_fetchKill = 1;
    drv();
    i_fetchReq  = 0;
    i_fetchKill = 0;
    @(negedge clk);
    chk("tk_idle_memReq", o_memReq, 0);

    // fetch 0x40 with ready held low 3 cycles
    ready_wait = 3;
    drv();
    i_fetchReq  = 1;
    i_fetchAddr = 32'h40;
    fq.push_back(32'h5A5A_0040);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t3_memReq", o_memReq, 1);
      chk("t3_addr", o_memAddr, 32'h40);
    end
    wait_valid(0);
    drv();
    i_fetchReq = 0;
    ready_wait = 0;

    // fetch 0x80 killed in WAIT, then 0x84 served
    hold_rv = 1;
    drv();
    i_fetchReq  = 1;
    i_fetchAddr = 32'h80;
    drv();
    drv();
    i_fetchKill = 1;
    drv();
    i_fetchKill = 0;
    i_fetchAddr = 32'h84;
    fq.push_back(32'h5A5A_0084);
    drv();
    hold_rv = 0;
    begin
      bit got = 0;
      for (int i = 0; i < 20 && !got; i++) begin
        @(negedge clk);
        chk("t4_noValid", o_fetchValid, 0);
        got = o_memReq;
      end
      if (!got) chk("t4_reissue_timeout", 0, 1);
    end
    chk("t4_addr84", o_memAddr, 32'h84);
    wait_valid(0);
    drv();
    i_fetchReq = 0;

    // reset while in WAIT, stale rvalid afterwards
    hold_rv = 1;
    drv();
    i_fetchReq  = 1;
    i_fetchAddr = 32'h300;
    drv();
    drv();
    reset      = 1;
    i_fetchReq = 0;
    @(negedge clk);
    chk("t5_rst_memReq", o_memReq, 0);
    drv();
    reset   = 0;
    hold_rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_memReq", o_memReq, 0);
      chk("t5_fValid", o_fetchValid, 0);
      chk("t5_fData", o_fetchData, 0);
    end

    chk("dq_empty", dq.size(), 0);
    chk("fq_empty", fq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
